// File: rtl/round_pack_arbiter_pkg.sv
// Shared types and constants for the roundAndPackFloat64 request arbiter.
package round_pack_arbiter_pkg;

   // Operand and result widths of the roundAndPackFloat64 core.
   localparam int EXP_W  = 13;
   localparam int SIG_W  = 64;
   localparam int FLAG_W = 32;

   // Exception flag bits as raised by the core (softfloat encoding).
   localparam logic [FLAG_W-1:0] FLAG_INEXACT   = 32'h0000_0001;
   localparam logic [FLAG_W-1:0] FLAG_UNDERFLOW = 32'h0000_0002;
   localparam logic [FLAG_W-1:0] FLAG_OVERFLOW  = 32'h0000_0004;
   localparam logic [FLAG_W-1:0] FLAG_DIVBYZERO = 32'h0000_0008;
   localparam logic [FLAG_W-1:0] FLAG_INVALID   = 32'h0000_0010;

   // Controller states: wait for a request, start the core, wait for done,
   // present the result.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // One requester's operand set, latched as a unit on acceptance.
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] expo;
      logic [SIG_W-1:0] sig;
   } operand_t;

   // Next requester index after idx, wrapping at n.
   function automatic int wrap_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/round_pack_arbiter_rr_arbiter.sv
// Round-robin grant: the first active request at or after the pointer wins.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            gnt_vld
);

   localparam int SUMW = IDW + 1;

   logic [NREQ-1:0] rot;
   logic [IDW-1:0]  off;
   logic [SUMW-1:0] sum;

   // Rotate requests so the pointer sits at bit 0, pick the lowest set bit,
   // then rotate the offset back into an absolute requester index.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path through it can leave a value held, which would infer a latch.
      rot     = NREQ'({req, req} >> ptr);
      off     = '0;
      sum     = '0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = |req;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = IDW'(k);
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= SUMW'(NREQ)) begin
         sum = sum - SUMW'(NREQ);
      end
      gnt_idx = sum[IDW-1:0];
      if (gnt_vld) begin
         gnt = NREQ'(1) << gnt_idx;
      end
   end

endmodule

// File: rtl/round_pack_arbiter.sv
// Shares one roundAndPackFloat64 core among NREQ requesters: round-robin
// accept, ap_ctrl_hs issue, response hold, and sticky exception flags.
module round_pack_arbiter
   import round_pack_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       req_sign,
   input  logic [NREQ*EXP_W-1:0] req_exp,
   input  logic [NREQ*SIG_W-1:0] req_sig,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [SIG_W-1:0]      rsp_data,
   output logic [FLAG_W-1:0]     rsp_flags,
   output logic [FLAG_W-1:0]     exc_flags,
   input  logic                  exc_clr,
   output logic                  core_start,
   input  logic                  core_done,
   input  logic                  core_idle,
   input  logic                  core_ready,
   output logic                  core_zSign,
   output logic [EXP_W-1:0]      core_zExp,
   output logic [SIG_W-1:0]      core_zSig,
   output logic [FLAG_W-1:0]     core_flag_i,
   input  logic [FLAG_W-1:0]     core_flag_o,
   input  logic                  core_flag_o_vld,
   input  logic [SIG_W-1:0]      core_return
);

   state_e          state;
   state_e          state_nxt;
   logic [IDW-1:0]  rr_ptr;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_vld;
   logic            accept;
   logic            capture;
   logic            hshk;
   logic            in_op;
   operand_t        req_op [NREQ];
   operand_t        op_q;
   logic [FLAG_W-1:0] op_flags;

   // core_idle carries nothing this controller needs; ap_ctrl_hs ready/done
   // already sequence the core.
   logic unused_core_idle;
   assign unused_core_idle = core_idle;

   // Slice the flat operand buses into one record per requester.
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign req_op[i] = {req_sign[i], req_exp[EXP_W*i +: EXP_W], req_sig[SIG_W*i +: SIG_W]};
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // State register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      // NOTE: clocked blocks use non-blocking assignments so every register
      // samples the values from before the edge, independent of block order.
      if (!ap_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-cycle strobes; core_done and flag pulses are
   // only looked at while an operation owns the core.
   always_comb begin
      state_nxt  = state;
      core_start = 1'b0;
      rsp_valid  = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      hshk       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (gnt_vld) begin
               accept    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            core_start = 1'b1;
            if (core_ready) begin
               if (core_done) begin
                  capture   = 1'b1;
                  state_nxt = ST_RESP;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (core_done) begin
               capture   = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               hshk      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign in_op = (state == ST_ISSUE) || (state == ST_WAIT);

   // The accept strobe is combinational from IDLE, so it is also qualified
   // by reset to keep req_ready low while reset is asserted.
   assign req_ready = (accept && ap_rst_n) ? gnt : '0;

   // Operands go to the core straight from the acceptance latch, so later
   // changes on req_* never reach an in-flight operation.
   assign core_zSign  = op_q.sign;
   assign core_zExp   = op_q.expo;
   assign core_zSig   = op_q.sig;
   assign core_flag_i = '0;

   // Operand latch, flag capture, response registers and round-robin pointer.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      // NOTE: the datapath is reset as well as the control, because every
      // output driven from these registers must read zero during reset.
      if (!ap_rst_n) begin
         op_q      <= '0;
         op_flags  <= '0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         rr_ptr    <= '0;
      end else begin
         if (accept) begin
            op_q     <= req_op[gnt_idx];
            rsp_id   <= gnt_idx;
            op_flags <= '0;
         end
         if (in_op && core_flag_o_vld) begin
            op_flags <= core_flag_o;
         end
         if (capture) begin
            rsp_data  <= core_return;
            rsp_flags <= core_flag_o_vld ? core_flag_o : op_flags;
         end
         if (hshk) begin
            rr_ptr <= IDW'(wrap_next(int'(rsp_id), NREQ));
         end
      end
   end

   // Sticky exception flags; a clear on the handshake cycle keeps only the
   // flags of the operation completing in that cycle.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         exc_flags <= '0;
      end else if (exc_clr) begin
         exc_flags <= hshk ? rsp_flags : '0;
      end else if (hshk) begin
         exc_flags <= exc_flags | rsp_flags;
      end
   end

endmodule

// File: tb/tb_round_pack_arbiter.sv
// Self-checking bench for round_pack_arbiter with a behavioural core model.
module tb_round_pack_arbiter;
   import round_pack_arbiter_pkg::*;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                  ap_clk = 1'b0;
   logic                  ap_rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       req_sign;
   logic [NREQ*EXP_W-1:0] req_exp;
   logic [NREQ*SIG_W-1:0] req_sig;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [SIG_W-1:0]      rsp_data;
   logic [FLAG_W-1:0]     rsp_flags;
   logic [FLAG_W-1:0]     exc_flags;
   logic                  exc_clr;
   logic                  core_start;
   logic                  core_done;
   logic                  core_idle;
   logic                  core_ready;
   logic                  core_zSign;
   logic [EXP_W-1:0]      core_zExp;
   logic [SIG_W-1:0]      core_zSig;
   logic [FLAG_W-1:0]     core_flag_i;
   logic [FLAG_W-1:0]     core_flag_o;
   logic                  core_flag_o_vld;
   logic [SIG_W-1:0]      core_return;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: round-robin pointer and sticky flags.
   int                m_ptr = 0;
   logic [FLAG_W-1:0] m_exc = '0;

   // Core behaviour for the next operation.
   int          cfg_lat   = 0;
   int          cfg_stall = 0;
   logic [63:0] cfg_ret   = '0;
   logic [31:0] cfg_flag  = '0;
   bit          cfg_fvld  = 1'b0;
   bit          cfg_fstart = 1'b0;
   bit          cfg_spur  = 1'b0;

   round_pack_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .ap_clk          (ap_clk),
      .ap_rst_n        (ap_rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_sign        (req_sign),
      .req_exp         (req_exp),
      .req_sig         (req_sig),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_id          (rsp_id),
      .rsp_data        (rsp_data),
      .rsp_flags       (rsp_flags),
      .exc_flags       (exc_flags),
      .exc_clr         (exc_clr),
      .core_start      (core_start),
      .core_done       (core_done),
      .core_idle       (core_idle),
      .core_ready      (core_ready),
      .core_zSign      (core_zSign),
      .core_zExp       (core_zExp),
      .core_zSig       (core_zSig),
      .core_flag_i     (core_flag_i),
      .core_flag_o     (core_flag_o),
      .core_flag_o_vld (core_flag_o_vld),
      .core_return     (core_return)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Core model: accepts start after cfg_stall cycles, done cfg_lat cycles
   // after acceptance (0 = same cycle); flags on done or at acceptance.
   initial begin : core_model
      int cnt;
      bit busy;
      int stalled;
      logic [63:0] ret_l;
      logic [31:0] flg_l;
      bit fvld_l;
      bit fstart_l;
      cnt = 0; busy = 1'b0; stalled = 0;
      ret_l = '0; flg_l = '0; fvld_l = 1'b0; fstart_l = 1'b0;
      core_ready = 1'b0; core_done = 1'b0; core_idle = 1'b1;
      core_flag_o = '0; core_flag_o_vld = 1'b0; core_return = '0;
      forever begin
         @(posedge ap_clk); #1;
         core_ready = 1'b0; core_done = 1'b0; core_flag_o_vld = 1'b0;
         core_flag_o = $urandom; core_idle = !busy;
         if (busy) begin
            cnt--;
            if (cnt == 0) begin
               busy = 1'b0; core_done = 1'b1; core_return = ret_l;
               if (fvld_l && !fstart_l) begin core_flag_o_vld = 1'b1; core_flag_o = flg_l; end
            end
         end else if (core_start) begin
            if (stalled < cfg_stall) begin
               stalled++;
            end else begin
               stalled = 0; core_ready = 1'b1;
               ret_l = cfg_ret; flg_l = cfg_flag; fvld_l = cfg_fvld; fstart_l = cfg_fstart;
               if (cfg_lat == 0) begin
                  core_done = 1'b1; core_return = ret_l;
                  if (fvld_l) begin core_flag_o_vld = 1'b1; core_flag_o = flg_l; end
               end else begin
                  busy = 1'b1; cnt = cfg_lat;
                  if (fvld_l && fstart_l) begin core_flag_o_vld = 1'b1; core_flag_o = flg_l; end
               end
            end
         end else if (cfg_spur) begin
            core_done = 1'b1; core_flag_o_vld = 1'b1; core_flag_o = '1;
            core_return = 64'hDEAD_BEEF_DEAD_BEEF;
         end
      end
   end

   // Round-robin rule: first valid requester at or after ptr, wrapping.
   function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic rand_operands();
      for (int i = 0; i < NREQ; i++) begin
         req_sign[i] = 1'($urandom);
         req_exp[EXP_W*i +: EXP_W] = EXP_W'($urandom);
         req_sig[SIG_W*i +: SIG_W] = {$urandom, $urandom};
      end
   endtask

   // Reset pulse; leaves the bench at posedge+1.
   task automatic apply_reset();
      @(negedge ap_clk); ap_rst_n = 1'b0;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      m_ptr = 0; m_exc = '0;
      @(posedge ap_clk); #1;
   endtask

   // One full operation, entered and left at posedge+1 with the DUT idle.
   task automatic do_op(input logic [NREQ-1:0] v, input int lat, input int stall,
                        input logic [63:0] ret, input logic [31:0] flg, input bit fvld,
                        input bit fstart, input bit clr, input int hold,
                        output logic [IDW-1:0] obs_id);
      int g;
      int k;
      int exp_k;
      logic e_sign;
      logic [EXP_W-1:0] e_exp;
      logic [SIG_W-1:0] e_sig;
      logic [31:0] e_flags;
      cfg_lat = lat; cfg_stall = stall; cfg_ret = ret; cfg_flag = flg;
      cfg_fvld = fvld; cfg_fstart = fstart;
      req_valid = v;
      g = model_grant(v, m_ptr);
      e_sign = req_sign[g];
      e_exp  = req_exp[EXP_W*g +: EXP_W];
      e_sig  = req_sig[SIG_W*g +: SIG_W];
      e_flags = fvld ? flg : 32'h0;
      @(negedge ap_clk);
      n_tests++;
      if (req_ready !== (NREQ'(1) << g))
         $display("FAIL grant: req_ready=%b expected %b (valid %b)", req_ready, NREQ'(1) << g, v);
      if (req_ready !== (NREQ'(1) << g)) n_fail++;
      @(posedge ap_clk); #1;
      req_valid = '0;
      rand_operands();
      exp_k = stall + lat + 1;
      k = 0;
      @(negedge ap_clk);
      n_tests++;
      if (core_start !== 1'b1) begin
         n_fail++; $display("FAIL start: core_start=%b expected 1", core_start);
      end
      while (rsp_valid !== 1'b1 && k < 40) begin
         if (core_start === 1'b1) begin
            n_tests++;
            if ({core_zSign, core_zExp, core_zSig} !== {e_sign, e_exp, e_sig}) begin
               n_fail++;
               $display("FAIL operands: got %b/%h/%h expected %b/%h/%h",
                        core_zSign, core_zExp, core_zSig, e_sign, e_exp, e_sig);
            end
         end
         @(negedge ap_clk); k++;
      end
      n_tests++;
      if (k !== exp_k) begin
         n_fail++; $display("FAIL latency: rsp_valid after %0d cycles expected %0d", k, exp_k);
      end
      obs_id = rsp_id;
      n_tests++;
      if (rsp_id !== IDW'(g) || rsp_data !== ret || rsp_flags !== e_flags || core_start !== 1'b0) begin
         n_fail++;
         $display("FAIL response: id=%0d data=%h flags=%h start=%b expected id=%0d data=%h flags=%h start=0",
                  rsp_id, rsp_data, rsp_flags, core_start, g, ret, e_flags);
      end
      req_valid = '1;
      for (int h = 0; h < hold; h++) begin
         @(negedge ap_clk);
         n_tests++;
         if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g) || rsp_data !== ret || rsp_flags !== e_flags ||
             core_start !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL hold: valid=%b id=%0d data=%h flags=%h start=%b ready=%b expected 1/%0d/%h/%h/0/0",
                     rsp_valid, rsp_id, rsp_data, rsp_flags, core_start, req_ready, g, ret, e_flags);
         end
      end
      rsp_ready = 1'b1; exc_clr = clr;
      @(posedge ap_clk); #1;
      rsp_ready = 1'b0; exc_clr = 1'b0; req_valid = '0;
      m_ptr = (g + 1) % NREQ;
      m_exc = clr ? e_flags : (m_exc | e_flags);
      n_tests++;
      if (exc_flags !== m_exc || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL exc: exc_flags=%h rsp_valid=%b expected %h/0", exc_flags, rsp_valid, m_exc);
      end
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0; exc_clr = 1'b0;
      rand_operands();
      repeat (2) @(negedge ap_clk);
      n_tests++;
      if (req_ready !== '0) begin
         n_fail++; $display("FAIL reset_ready: req_ready=%b expected 0", req_ready);
      end
      n_tests++;
      if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 || rsp_flags !== '0 || exc_flags !== '0) begin
         n_fail++;
         $display("FAIL reset_rsp: valid=%b id=%0d data=%h flags=%h exc=%h expected all 0",
                  rsp_valid, rsp_id, rsp_data, rsp_flags, exc_flags);
      end
      n_tests++;
      if (core_start !== 1'b0 || core_zSign !== 1'b0 || core_zExp !== '0 || core_zSig !== '0 || core_flag_i !== '0) begin
         n_fail++;
         $display("FAIL reset_core: start=%b sign=%b exp=%h sig=%h flag_i=%h expected all 0",
                  core_start, core_zSign, core_zExp, core_zSig, core_flag_i);
      end
      req_valid = '0;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
   endtask

   task automatic test_idle();
      req_valid = '0;
      @(negedge ap_clk);
      n_tests++;
      if (req_ready !== '0) begin
         n_fail++; $display("FAIL idle_ready: req_ready=%b expected 0", req_ready);
      end
      @(posedge ap_clk); #1;
      @(negedge ap_clk);
      n_tests++;
      if (core_start !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL idle_quiet: start=%b rsp_valid=%b expected 0/0", core_start, rsp_valid);
      end
      @(posedge ap_clk); #1;
   endtask

   task automatic test_single_op();
      logic [IDW-1:0] id;
      rand_operands();
      req_sign[2] = 1'b0;
      req_exp[EXP_W*2 +: EXP_W] = 13'h3FF;
      req_sig[SIG_W*2 +: SIG_W] = 64'h4000_0000_0000_0000;
      do_op(4'b0100, 3, 0, 64'h3FF0_0000_0000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 0, id);
      n_tests++;
      if (id !== 2'd2) begin
         n_fail++; $display("FAIL single_id: rsp_id=%0d expected 2", id);
      end
   endtask

   task automatic test_round_robin();
      logic [IDW-1:0] id;
      apply_reset();
      for (int n = 0; n < 5; n++) begin
         rand_operands();
         do_op('1, 0, 0, {$urandom, $urandom}, 32'h0, 1'b0, 1'b0, 1'b0, 0, id);
         n_tests++;
         if (id !== IDW'(n % NREQ)) begin
            n_fail++; $display("FAIL rr_order: op %0d granted %0d expected %0d", n, id, n % NREQ);
         end
      end
   endtask

   task automatic test_resp_hold();
      logic [IDW-1:0] id;
      rand_operands();
      do_op(4'b1010, 1, 2, {$urandom, $urandom}, 32'h0, 1'b0, 1'b0, 1'b0, 5, id);
   endtask

   task automatic test_flags();
      logic [IDW-1:0] id;
      rand_operands();
      do_op(4'b0001, 0, 0, {$urandom, $urandom}, FLAG_INEXACT, 1'b1, 1'b0, 1'b0, 0, id);
      n_tests++;
      if (exc_flags !== 32'h1) begin
         n_fail++; $display("FAIL flags_first: exc_flags=%h expected 00000001", exc_flags);
      end
      rand_operands();
      do_op(4'b0110, 2, 0, {$urandom, $urandom}, FLAG_OVERFLOW, 1'b1, 1'b0, 1'b1, 1, id);
      n_tests++;
      if (exc_flags !== 32'h4) begin
         n_fail++; $display("FAIL flags_clr: exc_flags=%h expected 00000004", exc_flags);
      end
      rand_operands();
      do_op(4'b1000, 2, 1, {$urandom, $urandom}, FLAG_UNDERFLOW, 1'b1, 1'b1, 1'b0, 0, id);
      exc_clr = 1'b1;
      @(posedge ap_clk); #1;
      exc_clr = 1'b0;
      m_exc = '0;
      n_tests++;
      if (exc_flags !== '0) begin
         n_fail++; $display("FAIL flags_idle_clr: exc_flags=%h expected 0", exc_flags);
      end
   endtask

   task automatic test_spurious();
      logic [IDW-1:0] id;
      cfg_spur = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge ap_clk);
         n_tests++;
         if (rsp_valid !== 1'b0 || exc_flags !== m_exc) begin
            n_fail++;
            $display("FAIL spurious_idle: rsp_valid=%b exc=%h expected 0/%h", rsp_valid, exc_flags, m_exc);
         end
      end
      @(posedge ap_clk); #1;
      rand_operands();
      do_op(4'b0101, 2, 0, {$urandom, $urandom}, 32'h0, 1'b0, 1'b0, 1'b0, 3, id);
      cfg_spur = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      rand_operands();
      cfg_lat = 4; cfg_stall = 0; cfg_fvld = 1'b0; cfg_ret = 64'h1234_5678_9ABC_DEF0;
      req_valid = 4'b0010;
      @(posedge ap_clk); #1;
      req_valid = '0;
      @(posedge ap_clk); #1;
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      #1;
      n_tests++;
      if (rsp_valid !== 1'b0 || core_start !== 1'b0 || core_zSig !== '0 || rsp_id !== '0 || exc_flags !== '0) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b start=%b sig=%h id=%0d exc=%h expected all 0",
                  rsp_valid, core_start, core_zSig, rsp_id, exc_flags);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      m_ptr = 0; m_exc = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge ap_clk);
         n_tests++;
         if (rsp_valid !== 1'b0 || core_start !== 1'b0) begin
            n_fail++;
            $display("FAIL abandoned: cycle %0d rsp_valid=%b start=%b expected 0/0", c, rsp_valid, core_start);
         end
      end
      @(posedge ap_clk); #1;
      begin
         logic [IDW-1:0] id;
         rand_operands();
         do_op('1, 1, 0, {$urandom, $urandom}, 32'h0, 1'b0, 1'b0, 1'b0, 0, id);
         n_tests++;
         if (id !== '0) begin
            n_fail++; $display("FAIL post_reset_prio: granted %0d expected 0", id);
         end
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0] v;
      logic [IDW-1:0] id;
      for (int n = 0; n < 24; n++) begin
         rand_operands();
         v = NREQ'($urandom);
         if (v == '0) v = NREQ'(1) << $urandom_range(0, NREQ - 1);
         do_op(v, $urandom_range(0, 3), $urandom_range(0, 2), {$urandom, $urandom},
               32'($urandom_range(1, 31)), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 2), id);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_op();
      test_round_robin();
      test_resp_hold();
      test_flags();
      test_spurious();
      test_reset_in_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/round_pack_arbiter.md
ROUND_PACK_ARBITER -- requirements
Module: round_pack_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one roundAndPackFloat64 core.
REQ-002 SHALL have parameter IDW, default 2, requester-id width (clog2 NREQ).
REQ-003 ap_clk  in  1  single clock, all state on rising edge.
REQ-004 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  NREQ  per-requester operation request.
REQ-006 req_ready  out  NREQ  one-hot accept strobe.
REQ-007 req_sign  in  NREQ  zSign per requester.
REQ-008 req_exp  in  NREQ*13  zExp per requester; slice i = [13i+12:13i].
REQ-009 req_sig  in  NREQ*64  zSig per requester; slice i = [64i+63:64i].
REQ-010 rsp_valid  out  1 / rsp_ready  in  1  response handshake.
REQ-011 rsp_id  out  IDW / rsp_data  out  64 / rsp_flags  out  32  owner, packed result, flags raised by this operation.
REQ-012 exc_flags  out  32 / exc_clr  in  1  sticky accumulated flags and synchronous clear.
REQ-013 core_start out 1; core_done, core_idle, core_ready in 1; core_zSign out 1; core_zExp out 13; core_zSig out 64; core_flag_i out 32; core_flag_o in 32; core_flag_o_vld in 1; core_return in 64  ap_ctrl_hs link to the core.

Function
REQ-014 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: if any req_valid, grant highest-priority requester by round-robin from pointer rr_ptr; req_ready[grant]=1 for exactly that cycle; latch operands and id; go ISSUE. req_ready=0 in all other states.
REQ-016 ISSUE: core_start=1, core_zSign/zExp/zSig from latched operands, held stable until core_ready=1.
REQ-017 ISSUE with core_ready=1 and core_done=1 same cycle: capture core_return, go RESP; core_ready=1 without done: go WAIT.
REQ-018 WAIT: core_start=0; on core_done=1 capture core_return into rsp_data, go RESP.
REQ-019 core_flag_i SHALL be driven 0; op flags = core_flag_o latched on any core_flag_o_vld from ISSUE entry through done cycle, else 0.
REQ-020 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_flags stable until rsp_ready=1; on handshake rr_ptr = grant+1 mod NREQ, go IDLE.
REQ-021 Latency: accept at cycle T -> core_start from T+1; zero-latency core gives rsp_valid at T+2; rsp_valid SHALL be 1 cycle after core_done otherwise.
REQ-022 Maximum throughput one operation per 3 cycles; no overlap of operations on the core.
REQ-023 Round-robin SHALL be starvation-free: with all requesters valid, grants cycle 0,1,..,NREQ-1,0.
REQ-024 exc_flags |= rsp_flags on response handshake; exc_clr=1 clears; simultaneous clear and update yields exc_flags = rsp_flags only.
REQ-025 core_done or core_flag_o_vld in IDLE or RESP SHALL be ignored.
REQ-026 Operand changes on req_* after acceptance SHALL not affect the in-flight operation.

Reset
REQ-027 ap_rst_n low SHALL immediately force state IDLE, rr_ptr=0, and all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, exc_flags, core_start, core_z*, core_flag_i).
REQ-028 Reset mid-operation SHALL abandon the operation with no response; a core_done arriving after reset release SHALL be ignored.
REQ-029 After reset requester 0 has highest priority.

Structure
REQ-030 Shared package SHALL hold state enum, widths 13/64/32, and flag bit constants (inexact, underflow, overflow, divbyzero, invalid).
REQ-031 Round-robin grant logic SHALL be one sub-module rr_arbiter (request vector, pointer -> one-hot grant, index).
REQ-032 The core instance and its key ports are wired by the parent; this block only drives the ap_ctrl_hs and data ports.

Verification
REQ-033 Reset: ap_rst_n=0 with req_valid=4'hF -> all outputs 0, req_ready=0, exc_flags=0.
REQ-034 Requester 2 zSign=0 zExp=13'h3FF zSig=64'h4000000000000000, core done 3 cycles after start returning 64'h3FF0000000000000 -> rsp_id=2, rsp_data=64'h3FF0000000000000, rsp_flags=0, rsp_valid 1 cycle after done.
REQ-035 req_valid=4'hF held, rsp_ready=1 -> grant order 0,1,2,3,0 on consecutive operations.
REQ-036 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, core_start=0, req_ready=4'h0 throughout.
REQ-037 Core flag_o=32'h1 with vld -> rsp_flags=1, exc_flags=1; next op flag_o=32'h4 with exc_clr on its handshake cycle -> exc_flags=32'h4.
REQ-038 ap_rst_n pulsed low in WAIT, core_done 2 cycles later -> no rsp_valid, state IDLE, core_start=0.
